// File: rtl/envelope_follower.sv
// Envelope follower: rectifies a signed sample stream, smooths it with shift-coded
// attack/release steps, and derives a hysteretic gate with a hold-off counter.
module envelope_follower #(
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic [3:0]           a,
  input  logic [3:0]           r,
  input  logic [7:0]           on_thresh,
  input  logic [7:0]           off_thresh,
  input  logic [7:0]           hold,
  output logic [7:0]           amplitude,
  output logic                 amplitude_valid,
  output logic                 gate
);

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_HOLD   = 2'd2
  } gate_state_t;

  localparam logic [DATA_BITS-1:0] MAG_MAX = {1'b0, {(DATA_BITS-1){1'b1}}};

  // Stage 1: rectification
  logic [DATA_BITS-1:0] abs_full;
  logic [DATA_BITS-2:0] mag;
  logic [7:0]           target_in;

  logic                 s1_valid;
  logic [7:0]           target;

  // Stage 2: envelope step and gate FSM
  logic [7:0]           diff;
  logic [7:0]           step;
  logic [7:0]           env_next;

  gate_state_t          state;
  gate_state_t          state_next;
  logic [7:0]           hcnt;
  logic [7:0]           hcnt_next;

  // The most negative code has no positive counterpart, so it saturates.
  assign abs_full  = sample_in[DATA_BITS-1] ? (~sample_in + 1'b1) : sample_in;
  assign mag       = (abs_full > MAG_MAX) ? MAG_MAX[DATA_BITS-2:0]
                                          : abs_full[DATA_BITS-2:0];
  assign target_in = 8'(mag >> (DATA_BITS - 9));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      target   <= 8'd0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        target <= target_in;
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    diff     = 8'd0;
    step     = 8'd0;
    env_next = amplitude;
    if (target > amplitude) begin
      diff = target - amplitude;
      step = diff >> a;
      if (step == 8'd0) begin
        step = 8'd1;
      end
      env_next = amplitude + step;
    end else if (target < amplitude) begin
      diff = amplitude - target;
      step = diff >> r;
      if (step == 8'd0) begin
        step = 8'd1;
      end
      env_next = amplitude - step;
    end
  end

  // Transitions use the freshly computed envelope, not the registered one.
  always_comb begin
    state_next = state;
    hcnt_next  = hcnt;
    if (s1_valid) begin
      unique case (state)
        ST_CLOSED: begin
          if (env_next >= on_thresh) begin
            state_next = ST_OPEN;
          end
        end
        ST_OPEN: begin
          if (env_next < off_thresh) begin
            if (hold != 8'd0) begin
              state_next = ST_HOLD;
              hcnt_next  = hold;
            end else begin
              state_next = ST_CLOSED;
            end
          end
        end
        ST_HOLD: begin
          if (env_next >= on_thresh) begin
            state_next = ST_OPEN;
          end else if (hcnt == 8'd1) begin
            state_next = ST_CLOSED;
            hcnt_next  = 8'd0;
          end else begin
            hcnt_next = hcnt - 8'd1;
          end
        end
        default: begin
          state_next = ST_CLOSED;
          hcnt_next  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amplitude       <= 8'd0;
      amplitude_valid <= 1'b0;
      state           <= ST_CLOSED;
      hcnt            <= 8'd0;
    end else begin
      amplitude_valid <= s1_valid;
      state           <= state_next;
      hcnt            <= hcnt_next;
      if (s1_valid) begin
        amplitude <= env_next;
      end
    end
  end

  assign gate = (state != ST_CLOSED);

endmodule

// File: tb/tb_envelope_follower.sv
// Directed self-checking bench for envelope_follower: reset, attack shapes,
// rectification, release with hold, retrigger and reset during an update.
module tb_envelope_follower;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [3:0]  a;
  logic [3:0]  r;
  logic [7:0]  on_thresh;
  logic [7:0]  off_thresh;
  logic [7:0]  hold;
  logic [7:0]  amplitude;
  logic        amplitude_valid;
  logic        gate;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  envelope_follower #(.DATA_BITS(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .a               (a),
    .r               (r),
    .on_thresh       (on_thresh),
    .off_thresh      (off_thresh),
    .hold            (hold),
    .amplitude       (amplitude),
    .amplitude_valid (amplitude_valid),
    .gate            (gate)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_outputs(input string tag, input int amp, input int vld, input int gt);
    check({tag, ".amp"},   amplitude,       amp);
    check({tag, ".valid"}, amplitude_valid, vld);
    check({tag, ".gate"},  gate,            gt);
  endtask

  // Strobe one sample, then observe at the negedge after the N+2 edge.
  task automatic update(input logic [11:0] s, input string tag, input int amp, input int gt);
    @(negedge clk);
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = 12'($urandom);
    @(negedge clk);
    expect_outputs(tag, amp, 1, gt);
  endtask

  localparam logic [11:0] S_MAX = 12'h7FF;
  localparam logic [11:0] S_MIN = 12'h800;

  int shaped [20] = '{63, 111, 147, 174, 194, 209, 220, 228, 234, 239,
                      243, 246, 248, 249, 250, 251, 252, 253, 254, 255};
  int rel_amp [8] = '{128, 64, 32, 16, 8, 4, 2, 1};
  int rel_gate[8] = '{1, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    // Reset with random inputs, including random strobes.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_in    = 12'($urandom);
      sample_valid = 1'($urandom);
      a            = 4'($urandom);
      r            = 4'($urandom);
      on_thresh    = 8'($urandom);
      off_thresh   = 8'($urandom);
      hold         = 8'($urandom);
      @(negedge clk);
    end
    expect_outputs("reset", 0, 0, 0);
    sample_valid = 1'b0;
    rst          = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      expect_outputs("idle_after_reset", 0, 0, 0);
    end

    // Instant attack with exact latency.
    a = 4'd0; r = 4'd0; on_thresh = 8'd64; off_thresh = 8'd16; hold = 8'd0;
    sample_in    = S_MAX;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    expect_outputs("attack_n1", 0, 0, 0);
    @(negedge clk);
    expect_outputs("attack_n2", 255, 1, 1);
    @(negedge clk);
    expect_outputs("attack_n3", 255, 0, 1);
    @(negedge clk);
    expect_outputs("attack_hold", 255, 0, 1);

    // Shaped attack from zero.
    update(12'd0, "to_zero", 0, 0);
    a = 4'd2;
    for (int i = 0; i < 20; i++) begin
      update(S_MAX, $sformatf("shaped%0d", i), shaped[i], (i == 0) ? 0 : 1);
    end
    update(S_MAX, "shaped_settled", 255, 1);

    // Rectification with immediate tracking.
    a = 4'd0; r = 4'd0;
    update(S_MIN,   "rect_m2048", 255, 1);
    update(12'hFF8, "rect_m8",    1,   0);
    update(12'd7,   "rect_p7",    0,   0);
    update(12'd8,   "rect_p8",    1,   0);
    update(12'hFF0, "rect_m16",   2,   0);

    // Release with hold = 3.
    update(S_MAX, "rel_setup", 255, 1);
    r = 4'd1; off_thresh = 8'd16; hold = 8'd3;
    for (int i = 0; i < 8; i++) begin
      update(12'd0, $sformatf("rel_hold%0d", i), rel_amp[i], rel_gate[i]);
    end

    // Release with hold = 0.
    a = 4'd0;
    update(S_MAX, "rel0_setup", 255, 1);
    hold = 8'd0;
    for (int i = 0; i < 5; i++) begin
      update(12'd0, $sformatf("rel_nohold%0d", i), rel_amp[i], (i == 4) ? 0 : 1);
    end

    // Retrigger out of HOLD, then sit between thresholds: OPEN must persist.
    a = 4'd0; r = 4'd0; hold = 8'd5;
    update(S_MAX, "retrig_open", 255, 1);
    update(12'd0, "retrig_hold", 0,   1);
    update(S_MAX, "retrig_back", 255, 1);
    for (int i = 0; i < 7; i++) begin
      update(12'd256, $sformatf("retrig_mid%0d", i), 32, 1);
    end

    // Back-to-back strobes, then reset before the second one lands.
    @(negedge clk);
    sample_in    = S_MAX;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_in    = 12'd0;
    @(negedge clk);
    sample_valid = 1'b0;
    expect_outputs("b2b_first", 255, 1, 1);
    #1 rst = 1'b0;
    #1 expect_outputs("midreset_async", 0, 0, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_outputs($sformatf("midreset_after%0d", i), 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Measures the amplitude of a signed 12-bit audio sample stream and produces an 8-bit envelope plus a hysteretic, hold-extended gate. It is the analysis counterpart of `envelope_generator`: where that block turns a gate and ADSR settings into an amplitude, this block turns audio back into an amplitude and a gate. Typical uses are external-input triggering, ducking and envelope-driven modulation. It sits on the sample-rate enable domain alongside the voice and filter blocks.

## Interface
- `DATA_BITS`, 12: width of `sample_in`, signed two's complement. The magnitude arithmetic below is defined for 12.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `sample_in` input, `DATA_BITS` bits: signed audio sample, sampled when `sample_valid` is high.
- `sample_valid` input, 1 bit: one-cycle strobe qualifying `sample_in`. May be high on consecutive cycles.
- `a` input, 4 bits: attack shift code.
- `r` input, 4 bits: release shift code.
- `on_thresh` input, 8 bits: gate opening threshold.
- `off_thresh` input, 8 bits: gate closing threshold.
- `hold` input, 8 bits: number of updates the gate is held open after the envelope falls below `off_thresh`.
- `amplitude` output, 8 bits: current envelope value.
- `amplitude_valid` output, 1 bit: one-cycle strobe marking a new `amplitude` value.
- `gate` output, 1 bit: high in the OPEN and HOLD states.

## Operation
- Stage 1 (the cycle after `sample_valid`): rectify the sample.
  - mag = |sample_in|; -2048 saturates to 2047, so mag is an 11-bit value.
  - target = mag[10:3], giving a range of 0..255. The target is registered.
- Stage 2 (envelope update), with env = `amplitude`:
  - If target > env: diff = target - env; step = diff >> a; if step is 0 and diff is nonzero, step = 1. New env = env + step.
  - If target < env: the same calculation, using env - target and r, and subtracting the step.
  - If target == env: env is unchanged.
  - The step never exceeds diff, so env cannot overshoot, wrap or overflow.
  - Codes of 8 to 15 produce a step of 1 for every nonzero diff.
- Gate FSM. Transitions are evaluated only on stage-2 updates, using the new env value:
  - CLOSED: go to OPEN if env >= on_thresh.
  - OPEN: if env < off_thresh, go to HOLD when `hold` > 0 (load hcnt = `hold`), or go straight to CLOSED when `hold` = 0. Otherwise stay in OPEN.
  - HOLD: if env >= on_thresh, go to OPEN. Otherwise, if hcnt is 1, go to CLOSED; if not, decrement hcnt.
- If on_thresh <= off_thresh, the FSM still follows these rules literally. Chatter in that configuration is permitted.
- The control inputs (`a`, `r`, thresholds, `hold`) are sampled at every stage-2 update and need not be held stable. `hold` is read only on the OPEN-to-HOLD transition.

## Timing
- Reset values: `amplitude` = 0, `amplitude_valid` = 0, `gate` = 0, FSM in CLOSED, hcnt = 0, stage-1 valid = 0, target = 0.
- Reset asserted mid-update discards any in-flight sample. No strobe is emitted for it after release.
- Latency:
  - `sample_valid` high in cycle N.
  - target registered at edge N+1.
  - `amplitude`, `gate` and `amplitude_valid` update at edge N+2.
  - `amplitude_valid` is high for exactly cycle N+2 and is driven registered.
- Throughput is one sample per cycle. Back-to-back strobes produce back-to-back `amplitude_valid` pulses, with each update using the previous update's env.
- Between strobes, all outputs hold their values.

## Test plan
- Reset: drive `rst` = 0 with random inputs. Require `amplitude` = 0, `gate` = 0, `amplitude_valid` = 0. After release with no strobes, all three stay 0.
- Instant attack: a = 0, on_thresh = 64, sample 2047 strobed in cycle N. Require `amplitude` = 255, `gate` = 1 and `amplitude_valid` = 1 in cycle N+2 only.
- Shaped attack: a = 2, env = 0, repeated samples of 2047. Require `amplitude` to go 63, 111, 147, 174, and to reach 255 with no overshoot.
- Rectification: -2048 gives target 255; -8 gives target 1; 7 gives target 0. Check each with a = 0, r = 0.
- Release and hold: env = 255, r = 1, off_thresh = 16, hold = 3, input 0.
  - Require `amplitude` 128, 64, 32, 16, 8.
  - `gate` stays 1 through the update to 8 and the next two updates, then drops to 0 on the third update after reaching 8.
  - Repeat with hold = 0: `gate` drops to 0 on the update that reaches 8.
- Retrigger and mid-reset: in HOLD, a sample of 2047 (a = 0) returns the FSM to OPEN with hcnt unused. Strobe on consecutive cycles, then assert `rst` between a strobe and its N+2 edge. Require no `amplitude_valid` pulse and all outputs 0.
